// File: rtl/sd_pkg.sv
// Shared definitions for the SD block engine: FSM encoding, result codes and
// the SD data-token byte values.
package sd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    R_TOKEN,
    R_DATA,
    R_HOLD,
    R_CRC,
    W_TOKEN,
    W_DATA,
    W_CRC_H,
    W_CRC_L,
    W_RESP,
    W_BUSY,
    FINISH
  } sd_state_t;

  localparam logic [2:0] ERR_OK            = 3'd0;
  localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_READ_CRC      = 3'd2;
  localparam logic [2:0] ERR_DATA_TOKEN    = 3'd3;
  localparam logic [2:0] ERR_WRITE_REJECT  = 3'd4;
  localparam logic [2:0] ERR_BUSY_TIMEOUT  = 3'd5;
  localparam logic [2:0] ERR_ABORTED       = 3'd6;

  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  localparam logic [2:0] RESP_ACCEPT = 3'b010;

  // Timeout counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sd_byte_xfer.sv
// One-byte transfer primitive on top of the SPI shifter: issues a single start
// pulse and reports completion once the shifter has been seen busy and then idle.
module sd_byte_xfer
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_go,
  input  logic       i_isRead,
  input  logic [7:0] i_txByte,
  input  logic       i_shBusy,
  input  logic [7:0] i_shDataOut,
  output logic       o_shStartRead,
  output logic       o_shStartWrite,
  output logic [7:0] o_shDataIn,
  output logic [7:0] o_rxByte,
  output logic       o_done
);

  logic       r_active;
  logic       r_pend;
  logic       r_isRead;
  logic       r_seenBusy;
  logic       r_startRead;
  logic       r_startWrite;
  logic       r_done;
  logic [7:0] r_tx;
  logic [7:0] r_rx;

  // r_pend delays the start until the shifter is idle; seenBusy absorbs the
  // shifter's one-cycle lag between start and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active     <= 1'b0;
      r_pend       <= 1'b0;
      r_isRead     <= 1'b0;
      r_seenBusy   <= 1'b0;
      r_startRead  <= 1'b0;
      r_startWrite <= 1'b0;
      r_done       <= 1'b0;
      r_tx         <= 8'h00;
      r_rx         <= 8'h00;
    end else begin
      r_startRead  <= 1'b0;
      r_startWrite <= 1'b0;
      r_done       <= 1'b0;
      if (!r_active) begin
        if (i_go) begin
          r_active   <= 1'b1;
          r_pend     <= 1'b1;
          r_seenBusy <= 1'b0;
          r_isRead   <= i_isRead;
          r_tx       <= i_txByte;
        end
      end else if (r_pend) begin
        if (!i_shBusy) begin
          r_pend       <= 1'b0;
          r_startRead  <= r_isRead;
          r_startWrite <= !r_isRead;
        end
      end else if (i_shBusy) begin
        r_seenBusy <= 1'b1;
      end else if (r_seenBusy) begin
        r_active <= 1'b0;
        r_done   <= 1'b1;
        r_rx     <= i_shDataOut;
      end
    end
  end

  assign o_shStartRead  = r_startRead;
  assign o_shStartWrite = r_startWrite;
  assign o_shDataIn     = r_tx;
  assign o_rxByte       = r_rx;
  assign o_done         = r_done;

endmodule

// File: rtl/sd_block_engine.sv
// SD single-block read/write sequencer: drives the byte shifter through token
// hunt, data streaming, CRC16 handling, data response and card-busy polling.
module sd_block_engine
  import sd_pkg::*;
#(
  parameter int unsigned BLOCK_LEN     = 512,
  parameter int unsigned TOKEN_TIMEOUT = 4096,
  parameter int unsigned BUSY_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_read,
  input  logic        cmd_write,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [2:0]  error,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        sh_start_write,
  output logic        sh_start_read,
  output logic [7:0]  sh_data_in,
  input  logic [7:0]  sh_data_out,
  input  logic        sh_busy,
  output logic        sh_crc_reset,
  output logic        sh_crc_source,
  input  logic [15:0] sh_crc_out
);

  sd_state_t   r_state;
  logic        r_inFlight;
  logic [10:0] r_byteCnt;
  logic [15:0] r_tmoCnt;
  logic [15:0] r_crcHold;
  logic [2:0]  r_err;
  logic        r_crcReset;
  logic        r_crcSrc;

  sd_state_t   w_nextState;
  logic        w_go;
  logic        w_goRead;
  logic [7:0]  w_tx;
  logic [7:0]  w_rx;
  logic        w_xDone;
  logic        w_errLoad;
  logic [2:0]  w_errVal;
  logic        w_crcReset;
  logic        w_srcLoad;
  logic        w_srcVal;
  logic        w_cntInc;
  logic        w_tmoInc;
  logic        w_latchCrc;
  logic [15:0] w_tmoNext;
  logic        w_boundary;
  logic        w_keepCnt;

  sd_byte_xfer u_xfer (
    .clk            (clk),
    .rst            (rst),
    .i_go           (w_go),
    .i_isRead       (w_goRead),
    .i_txByte       (w_tx),
    .i_shBusy       (sh_busy),
    .i_shDataOut    (sh_data_out),
    .o_shStartRead  (sh_start_read),
    .o_shStartWrite (sh_start_write),
    .o_shDataIn     (sh_data_in),
    .o_rxByte       (w_rx),
    .o_done         (w_xDone)
  );

  assign w_tmoNext  = satInc16(r_tmoCnt);
  assign w_boundary = !r_inFlight && (r_state != IDLE) && (r_state != FINISH);

  always_comb begin
    w_nextState = r_state;
    w_go        = 1'b0;
    w_goRead    = 1'b0;
    w_tx        = IDLE_BYTE;
    w_errLoad   = 1'b0;
    w_errVal    = ERR_OK;
    w_crcReset  = 1'b0;
    w_srcLoad   = 1'b0;
    w_srcVal    = 1'b0;
    w_cntInc    = 1'b0;
    w_tmoInc    = 1'b0;
    w_latchCrc  = 1'b0;
    if (r_state == IDLE) begin
      if (cmd_read) begin
        w_nextState = R_TOKEN;
        w_errLoad   = 1'b1;
        w_srcLoad   = 1'b1;
        w_srcVal    = 1'b1;
      end else if (cmd_write) begin
        w_nextState = W_TOKEN;
        w_errLoad   = 1'b1;
        w_srcLoad   = 1'b1;
      end
    end else if (r_state == FINISH) begin
      w_nextState = IDLE;
    end else if (w_boundary && abort) begin
      w_nextState = FINISH;
      w_errLoad   = 1'b1;
      w_errVal    = ERR_ABORTED;
    end else begin
      case (r_state)
        R_TOKEN: begin
          if (!r_inFlight) begin
            w_go     = 1'b1;
            w_goRead = 1'b1;
          end else if (w_xDone) begin
            if (w_rx == START_TOKEN) begin
              w_crcReset  = 1'b1;
              w_nextState = R_DATA;
            end else if (w_rx[7:4] == 4'h0) begin
              w_nextState = FINISH;
              w_errLoad   = 1'b1;
              w_errVal    = ERR_DATA_TOKEN;
            end else begin
              w_tmoInc = 1'b1;
              if ({1'b0, w_tmoNext} >= 17'(TOKEN_TIMEOUT)) begin
                w_nextState = FINISH;
                w_errLoad   = 1'b1;
                w_errVal    = ERR_TOKEN_TIMEOUT;
              end
            end
          end
        end
        R_DATA: begin
          if (!r_inFlight) begin
            w_go     = 1'b1;
            w_goRead = 1'b1;
            w_cntInc = 1'b1;
          end else if (w_xDone) begin
            w_nextState = R_HOLD;
          end
        end
        R_HOLD: begin
          if (rd_ready) begin
            w_nextState = (r_byteCnt == 11'(BLOCK_LEN)) ? R_CRC : R_DATA;
          end
        end
        R_CRC: begin
          if (!r_inFlight) begin
            w_go     = 1'b1;
            w_goRead = 1'b1;
            w_cntInc = 1'b1;
          end else if (w_xDone && (r_byteCnt == 11'd2)) begin
            w_nextState = FINISH;
            w_errLoad   = 1'b1;
            w_errVal    = (sh_crc_out == 16'h0000) ? ERR_OK : ERR_READ_CRC;
          end
        end
        W_TOKEN: begin
          if (!r_inFlight) begin
            w_go = 1'b1;
            w_tx = START_TOKEN;
          end else if (w_xDone) begin
            // Clear the CRC only after the token so it covers the data bytes alone.
            w_crcReset  = 1'b1;
            w_nextState = W_DATA;
          end
        end
        W_DATA: begin
          if (!r_inFlight) begin
            if (wr_valid) begin
              w_go     = 1'b1;
              w_tx     = wr_data;
              w_cntInc = 1'b1;
            end
          end else if (w_xDone && (r_byteCnt == 11'(BLOCK_LEN))) begin
            w_latchCrc  = 1'b1;
            w_nextState = W_CRC_H;
          end
        end
        W_CRC_H: begin
          if (!r_inFlight) begin
            w_go = 1'b1;
            w_tx = r_crcHold[15:8];
          end else if (w_xDone) begin
            w_nextState = W_CRC_L;
          end
        end
        W_CRC_L: begin
          if (!r_inFlight) begin
            w_go = 1'b1;
            w_tx = r_crcHold[7:0];
          end else if (w_xDone) begin
            w_nextState = W_RESP;
          end
        end
        W_RESP: begin
          if (!r_inFlight) begin
            w_go     = 1'b1;
            w_goRead = 1'b1;
          end else if (w_xDone) begin
            if (!w_rx[4]) begin
              if (w_rx[3:1] == RESP_ACCEPT) begin
                w_nextState = W_BUSY;
              end else begin
                w_nextState = FINISH;
                w_errLoad   = 1'b1;
                w_errVal    = ERR_WRITE_REJECT;
              end
            end else begin
              w_tmoInc = 1'b1;
              if ({1'b0, w_tmoNext} >= 17'(TOKEN_TIMEOUT)) begin
                w_nextState = FINISH;
                w_errLoad   = 1'b1;
                w_errVal    = ERR_TOKEN_TIMEOUT;
              end
            end
          end
        end
        W_BUSY: begin
          if (!r_inFlight) begin
            w_go     = 1'b1;
            w_goRead = 1'b1;
          end else if (w_xDone) begin
            if (w_rx == IDLE_BYTE) begin
              w_nextState = FINISH;
            end else begin
              w_tmoInc = 1'b1;
              if ({1'b0, w_tmoNext} >= 17'(BUSY_TIMEOUT)) begin
                w_nextState = FINISH;
                w_errLoad   = 1'b1;
                w_errVal    = ERR_BUSY_TIMEOUT;
              end
            end
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The data byte count must survive the R_DATA/R_HOLD ping-pong.
  assign w_keepCnt = ((r_state == R_DATA) && (w_nextState == R_HOLD)) ||
                     ((r_state == R_HOLD) && (w_nextState == R_DATA));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inFlight <= 1'b0;
      r_byteCnt  <= 11'd0;
      r_tmoCnt   <= 16'd0;
      r_crcHold  <= 16'h0000;
      r_err      <= ERR_OK;
      r_crcReset <= 1'b0;
      r_crcSrc   <= 1'b0;
    end else begin
      r_crcReset <= w_crcReset;
      if (w_go) begin
        r_inFlight <= 1'b1;
      end else if (w_xDone) begin
        r_inFlight <= 1'b0;
      end
      if ((w_nextState != r_state) && !w_keepCnt) begin
        r_byteCnt <= 11'd0;
      end else if (w_cntInc) begin
        r_byteCnt <= r_byteCnt + 11'd1;
      end
      if (w_nextState != r_state) begin
        r_tmoCnt <= 16'd0;
      end else if (w_tmoInc) begin
        r_tmoCnt <= w_tmoNext;
      end
      if (w_latchCrc) begin
        r_crcHold <= sh_crc_out;
      end
      if (w_errLoad) begin
        r_err <= w_errVal;
      end
      if (w_srcLoad) begin
        r_crcSrc <= w_srcVal;
      end
    end
  end

  assign busy          = (r_state != IDLE) && (r_state != FINISH);
  assign done          = (r_state == FINISH);
  assign error         = r_err;
  assign rd_data       = w_rx;
  assign rd_valid      = (r_state == R_HOLD) && !abort;
  assign wr_ready      = (r_state == W_DATA) && !r_inFlight && !abort;
  assign sh_crc_reset  = r_crcReset;
  assign sh_crc_source = r_crcSrc;

endmodule

// File: tb/tb_sd_block_engine.sv
// Scoreboard bench for sd_block_engine: a behavioural shifter/card model feeds
// MISO bytes and checks MOSI bytes; a monitor checks rd beats and result codes.
module tb_sd_block_engine;

  logic        clk;
  logic        rst;
  logic        cmd_read;
  logic        cmd_write;
  logic        abort;
  logic        busy;
  logic        done;
  logic [2:0]  error;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        sh_start_write;
  logic        sh_start_read;
  logic [7:0]  sh_data_in;
  logic [7:0]  sh_data_out;
  logic        sh_busy;
  logic        sh_crc_reset;
  logic        sh_crc_source;
  logic [15:0] sh_crc_out;

  logic [7:0] misoQ[$];
  logic [7:0] mosiExpQ[$];
  logic [7:0] rdExpQ[$];
  logic [2:0] errExpQ[$];

  int nChecks = 0;
  int nFails = 0;
  int startRdCnt = 0;
  int startWrCnt = 0;
  int startWhileBusy = 0;
  int doneCount = 0;
  int rdBeats = 0;

  logic [7:0] rdBlk [4];
  logic [7:0] wrBlk [4];

  sd_block_engine #(
    .BLOCK_LEN     (4),
    .TOKEN_TIMEOUT (8),
    .BUSY_TIMEOUT  (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_read       (cmd_read),
    .cmd_write      (cmd_write),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .sh_start_write (sh_start_write),
    .sh_start_read  (sh_start_read),
    .sh_data_in     (sh_data_in),
    .sh_data_out    (sh_data_out),
    .sh_busy        (sh_busy),
    .sh_crc_reset   (sh_crc_reset),
    .sh_crc_source  (sh_crc_source),
    .sh_crc_out     (sh_crc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC16-CCITT, polynomial 0x1021, zero seed, MSB first.
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic logic [15:0] crcBlock(input logic [7:0] b [4]);
    logic [15:0] c;
    c = 16'h0000;
    for (int k = 0; k < 4; k++) c = crcStep(c, b[k]);
    return c;
  endfunction

  // Shifter + card model: one-cycle start-to-busy latency, three busy cycles,
  // MISO bytes from misoQ (0xFF when empty), MOSI bytes checked against mosiExpQ.
  initial begin
    int phase;
    int cnt;
    logic isRd;
    logic [7:0] tx;
    logic [7:0] misoByte;
    logic [7:0] mosiByte;
    phase = 0;
    cnt = 0;
    isRd = 1'b0;
    tx = 8'h00;
    sh_busy = 1'b0;
    sh_data_out = 8'h00;
    sh_crc_out = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        sh_busy = 1'b0;
        sh_crc_out = 16'h0000;
      end else begin
        if (sh_crc_reset) sh_crc_out = 16'h0000;
        if (sh_start_read || sh_start_write) begin
          if (sh_busy || phase != 0) startWhileBusy++;
          if (sh_start_read) startRdCnt++;
          else startWrCnt++;
          isRd = sh_start_read;
          tx = sh_data_in;
          phase = 1;
        end else if (phase == 1) begin
          sh_busy = 1'b1;
          cnt = 3;
          phase = 2;
        end else if (phase == 2) begin
          if (cnt > 1) begin
            cnt--;
          end else begin
            if (isRd) begin
              misoByte = (misoQ.size() > 0) ? misoQ.pop_front() : 8'hFF;
              mosiByte = 8'hFF;
            end else begin
              misoByte = 8'hFF;
              mosiByte = tx;
              checkOutput("mosiExpAvail", 32'(mosiExpQ.size() > 0), 32'd1);
              if (mosiExpQ.size() > 0) checkOutput("mosiByte", 32'(mosiByte), 32'(mosiExpQ.pop_front()));
            end
            sh_crc_out = crcStep(sh_crc_out, sh_crc_source ? misoByte : mosiByte);
            sh_data_out = misoByte;
            sh_busy = 1'b0;
            phase = 0;
          end
        end
      end
    end
  end

  // Monitor: read beats and transfer results, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid && rd_ready) begin
          rdBeats++;
          checkOutput("rdExpAvail", 32'(rdExpQ.size() > 0), 32'd1);
          if (rdExpQ.size() > 0) checkOutput("rdData", 32'(rd_data), 32'(rdExpQ.pop_front()));
        end
        if (done) begin
          doneCount++;
          checkOutput("errExpAvail", 32'(errExpQ.size() > 0), 32'd1);
          if (errExpQ.size() > 0) checkOutput("errorCode", 32'(error), 32'(errExpQ.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic isWrite);
    if (isWrite) cmd_write = 1'b1;
    else cmd_read = 1'b1;
    tick();
    cmd_read = 1'b0;
    cmd_write = 1'b0;
  endtask

  task automatic waitDone(input string name, input int base);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (doneCount != base) break;
      tick();
    end
    if (doneCount == base) checkOutput(name, 32'(doneCount - base), 32'd1);
    repeat (3) tick();
  endtask

  task automatic waitValid(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      if (rd_valid) break;
      tick();
    end
    if (!rd_valid) checkOutput(name, 32'(rd_valid), 32'd1);
  endtask

  task automatic clearCounts();
    startRdCnt = 0;
    startWrCnt = 0;
  endtask

  task automatic queueReadBlock(input int nIdle, input logic [7:0] crcLoXor);
    logic [15:0] c;
    c = crcBlock(rdBlk);
    misoQ.delete();
    rdExpQ.delete();
    repeat (nIdle) misoQ.push_back(8'hFF);
    misoQ.push_back(8'hFE);
    for (int i = 0; i < 4; i++) begin
      misoQ.push_back(rdBlk[i]);
      rdExpQ.push_back(rdBlk[i]);
    end
    misoQ.push_back(c[15:8]);
    misoQ.push_back(c[7:0] ^ crcLoXor);
  endtask

  task automatic queueWriteBlock();
    logic [15:0] c;
    c = crcBlock(wrBlk);
    mosiExpQ.delete();
    mosiExpQ.push_back(8'hFE);
    for (int i = 0; i < 4; i++) mosiExpQ.push_back(wrBlk[i]);
    mosiExpQ.push_back(c[15:8]);
    mosiExpQ.push_back(c[7:0]);
  endtask

  task automatic feedWrite(input int nBytes);
    logic got;
    for (int i = 0; i < nBytes; i++) begin
      wr_data = wrBlk[i];
      wr_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 500 && !got; k++) begin
        @(negedge clk);
        if (wr_ready) got = 1'b1;
      end
      tick();
      if (!got) checkOutput("wrAccept", 32'(got), 32'd1);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int base;
    int beatBase;
    int sBefore;
    logic stable;
    logic [7:0] hold;

    rdBlk[0] = 8'h3C; rdBlk[1] = 8'h5A; rdBlk[2] = 8'hC3; rdBlk[3] = 8'h01;
    wrBlk[0] = 8'hA0; wrBlk[1] = 8'hA1; wrBlk[2] = 8'hA2; wrBlk[3] = 8'hA3;
    rst = 1'b1;
    cmd_read = 1'b0;
    cmd_write = 1'b0;
    abort = 1'b0;
    rd_ready = 1'b1;
    wr_data = 8'h00;
    wr_valid = 1'b0;
    repeat (3) tick();
    checkOutput("resetOutputs",
                32'({busy, done, rd_valid, wr_ready, sh_start_read, sh_start_write, sh_crc_reset, error}),
                32'd0);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] read with two idle bytes and good CRC");
    queueReadBlock(2, 8'h00);
    errExpQ.push_back(3'd0);
    clearCounts();
    base = doneCount;
    applyStimulus(1'b0);
    waitDone("readDoneTimeout", base);
    checkOutput("readXfers", 32'(startRdCnt + startWrCnt), 32'd9);

    $display("[TB] read with corrupted CRC low byte");
    queueReadBlock(0, 8'h01);
    errExpQ.push_back(3'd2);
    base = doneCount;
    applyStimulus(1'b0);
    waitDone("crcErrDoneTimeout", base);

    $display("[TB] card data-error token");
    misoQ.delete();
    misoQ.push_back(8'h05);
    errExpQ.push_back(3'd3);
    clearCounts();
    base = doneCount;
    applyStimulus(1'b0);
    waitDone("dataTokDoneTimeout", base);
    checkOutput("dataTokXfers", 32'(startRdCnt), 32'd1);

    $display("[TB] read with consumer stall on byte 2");
    queueReadBlock(1, 8'h00);
    errExpQ.push_back(3'd0);
    rd_ready = 1'b0;
    base = doneCount;
    applyStimulus(1'b0);
    waitValid("stallBeat1Timeout");
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    waitValid("stallBeat2Timeout");
    hold = rd_data;
    sBefore = startRdCnt;
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (rd_data !== hold || !rd_valid) stable = 1'b0;
    end
    checkOutput("stallDataStable", 32'(stable), 32'd1);
    checkOutput("stallNoStart", 32'(startRdCnt), 32'(sBefore));
    rd_ready = 1'b1;
    waitDone("stallDoneTimeout", base);

    $display("[TB] write accepted, three busy bytes");
    queueWriteBlock();
    misoQ.delete();
    misoQ.push_back(8'hE5);
    repeat (3) misoQ.push_back(8'h00);
    misoQ.push_back(8'hFF);
    errExpQ.push_back(3'd0);
    clearCounts();
    base = doneCount;
    applyStimulus(1'b1);
    feedWrite(4);
    waitDone("writeDoneTimeout", base);
    checkOutput("writeWrXfers", 32'(startWrCnt), 32'd7);
    checkOutput("writeRdXfers", 32'(startRdCnt), 32'd5);

    $display("[TB] write rejected by card");
    queueWriteBlock();
    misoQ.delete();
    misoQ.push_back(8'hEB);
    errExpQ.push_back(3'd4);
    clearCounts();
    base = doneCount;
    applyStimulus(1'b1);
    feedWrite(4);
    waitDone("rejectDoneTimeout", base);
    checkOutput("rejectRdXfers", 32'(startRdCnt), 32'd1);

    $display("[TB] read token timeout");
    misoQ.delete();
    errExpQ.push_back(3'd1);
    clearCounts();
    base = doneCount;
    applyStimulus(1'b0);
    waitDone("tokTmoDoneTimeout", base);
    checkOutput("tokTmoXfers", 32'(startRdCnt), 32'd8);

    $display("[TB] abort during read byte 2");
    queueReadBlock(1, 8'h00);
    rdExpQ.delete();
    rdExpQ.push_back(rdBlk[0]);
    errExpQ.push_back(3'd6);
    clearCounts();
    base = doneCount;
    beatBase = rdBeats;
    applyStimulus(1'b0);
    for (int k = 0; k < 500 && rdBeats == beatBase; k++) tick();
    for (int k = 0; k < 50 && !sh_busy; k++) tick();
    checkOutput("abortByte2Busy", 32'(sh_busy), 32'd1);
    abort = 1'b1;
    waitDone("abortDoneTimeout", base);
    abort = 1'b0;
    checkOutput("abortXfers", 32'(startRdCnt), 32'd4);

    $display("[TB] reset in the middle of a write");
    queueWriteBlock();
    misoQ.delete();
    clearCounts();
    applyStimulus(1'b1);
    wr_data = wrBlk[0];
    wr_valid = 1'b1;
    for (int k = 0; k < 200 && startWrCnt < 2; k++) tick();
    checkOutput("midWriteStarted", 32'(startWrCnt), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midWriteReset",
                32'({busy, done, rd_valid, wr_ready, sh_start_read, sh_start_write, sh_crc_reset, error}),
                32'd0);
    wr_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    mosiExpQ.delete();
    repeat (2) tick();

    $display("[TB] read after reset recovery");
    misoQ.delete();
    misoQ.push_back(8'h07);
    errExpQ.push_back(3'd3);
    base = doneCount;
    applyStimulus(1'b0);
    waitDone("recoverDoneTimeout", base);

    checkOutput("startWhileBusy", 32'(startWhileBusy), 32'd0);
    checkOutput("rdExpLeft", 32'(rdExpQ.size()), 32'd0);
    checkOutput("errExpLeft", 32'(errExpQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
